error_rns_lift: RTL

ERROR_RNS_LIFT -- requirements
Module: error_rns_lift

---
 rtl/error_rns_lift_pkg.sv | 29 ++
 rtl/error_rns_lift_signed_mod_lift.sv | 17 +
 rtl/error_rns_lift.sv | 130 +++++++++++++
 3 files changed

// File: rtl/error_rns_lift_pkg.sv
// rtl/error_rns_lift_pkg.sv - shared widths, source select and ternary codes for the RNS lift
package error_rns_lift_pkg;

  localparam int N      = 8192;
  localparam int LOG_N  = 13;
  localparam int CBD_W  = 6;
  localparam int TERN_W = 2;
  localparam int COEF_W = 54;

  typedef enum logic [1:0] {
    SEL_E0  = 2'd0,
    SEL_E1  = 2'd1,
    SEL_V   = 2'd2,
    SEL_RSV = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [TERN_W-1:0] TERN_ZERO = 2'b00;
  localparam logic [TERN_W-1:0] TERN_POS  = 2'b01;
  localparam logic [TERN_W-1:0] TERN_BAD  = 2'b10;
  localparam logic [TERN_W-1:0] TERN_NEG  = 2'b11;

endpackage

// File: rtl/error_rns_lift_signed_mod_lift.sv
// rtl/error_rns_lift_signed_mod_lift.sv - maps a small signed value into [0, q)
module signed_mod_lift
  import error_rns_lift_pkg::*;
(
  input  logic [CBD_W-1:0]  i_x,
  input  logic [COEF_W-1:0] i_q,
  output logic [COEF_W-1:0] o_res
);

  logic [CBD_W-1:0] w_mag;

  // Magnitude of -32 wraps to 6'b100000, which is still the correct unsigned 32.
  assign w_mag = i_x[CBD_W-1] ? (~i_x + CBD_W'(1)) : i_x;
  assign o_res = i_x[CBD_W-1] ? (i_q - {{(COEF_W-CBD_W){1'b0}}, w_mag})
                              : {{(COEF_W-CBD_W){1'b0}}, i_x};

endmodule

// File: rtl/error_rns_lift.sv
// rtl/error_rns_lift.sv - streams one small-coefficient polynomial into an RNS residue channel
module error_rns_lift
  import error_rns_lift_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int N      = error_rns_lift_pkg::N
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [1:0]          i_sel,
  input  logic [COEF_W-1:0]   i_q,
  output logic [LOG_N-1:0]    o_rd_addr,
  input  logic [CBD_W-1:0]    i_rd_data_e0,
  input  logic [CBD_W-1:0]    i_rd_data_e1,
  input  logic [TERN_W-1:0]   i_rd_data_v,
  output logic [LOG_N-1:0]    o_wr_addr,
  output logic [COEF_W-1:0]   o_wr_data,
  output logic                o_wea,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_bad_code
);

  localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);

  state_e             r_state, w_state_nxt;
  sel_e               r_sel;
  logic [COEF_W-1:0]  r_q;
  logic [LOG_N-1:0]   r_rd_addr, r_wr_addr;
  logic [COEF_W-1:0]  r_wr_data;
  logic               r_wea, r_bad_code;
  logic               r_vld [RD_LAT];
  logic [LOG_N-1:0]   r_adr [RD_LAT];
  logic               w_accept, w_last_rd, w_last_wr, w_vld_c;
  logic [CBD_W-1:0]   w_x;
  logic [COEF_W-1:0]  w_lift;

  assign w_accept  = i_start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_last_rd = (r_rd_addr == LAST);
  assign w_last_wr = r_wea && (r_wr_addr == LAST);
  assign w_vld_c   = r_vld[RD_LAT-1];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) w_state_nxt = (sel_e'(i_sel) == SEL_RSV) ? ST_DONE : ST_RUN;
      end
      ST_RUN:   if (w_last_rd) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_last_wr) w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Ternary v is widened to the same signed width as e0/e1 so one lift serves all sources.
  always_comb begin
    w_x = '0;
    case (r_sel)
      SEL_E0: w_x = i_rd_data_e0;
      SEL_E1: w_x = i_rd_data_e1;
      SEL_V: begin
        case (i_rd_data_v)
          TERN_POS: w_x = CBD_W'(1);
          TERN_NEG: w_x = '1;
          default:  w_x = '0;
        endcase
      end
      default: w_x = '0;
    endcase
  end

  signed_mod_lift u_lift (
    .i_x   (w_x),
    .i_q   (r_q),
    .o_res (w_lift)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sel      <= SEL_E0;
      r_q        <= '0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wea      <= 1'b0;
      r_bad_code <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_vld[i] <= 1'b0;
        r_adr[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_sel     <= sel_e'(i_sel);
        r_q       <= i_q;
        r_rd_addr <= '0;
      end else if (r_state == ST_RUN && !w_last_rd) begin
        r_rd_addr <= r_rd_addr + LOG_N'(1);
      end
      // Every RUN cycle issues exactly one read; its tag emerges when the BRAM data does.
      r_vld[0] <= (r_state == ST_RUN);
      r_adr[0] <= r_rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_adr[i] <= r_adr[i-1];
      end
      r_wea <= w_vld_c;
      if (w_vld_c) begin
        r_wr_addr <= r_adr[RD_LAT-1];
        r_wr_data <= w_lift;
      end
      if (w_accept) begin
        r_bad_code <= 1'b0;
      end else if (w_vld_c && r_sel == SEL_V && i_rd_data_v == TERN_BAD) begin
        r_bad_code <= 1'b1;
      end
    end
  end

  assign o_rd_addr  = r_rd_addr;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_wea      = r_wea;
  assign o_busy     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign o_done     = (r_state == ST_DONE);
  assign o_bad_code = r_bad_code;

endmodule
